exp_led_pwm_multi: RTL

Parametrised successor to the 8-channel LED PWM tile. One shared ramp with a prescaler drives N PWM channels.
- Each channel has a writable brightness target, optional linear fading toward it, and an optional square-law (gamma) mapping.
- Channel phases are optionally staggered to spread LED current peaks.
- Duty updates are double-buffered so each channel changes only at its own period boundary.
- Sits between the top-level pin wrapper (ui_in/uio_in as the write bus) and uo_out.

---
 rtl/exp_led_pwm_multi.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/exp_led_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : exp_led_pwm_multi
//  Purpose  : N-channel LED PWM engine driven by one shared prescaled ramp.
//             Each channel holds a brightness target and a current level.
//             The level either jumps to the target on a write or slews one
//             LSB per fade step toward it. The level can be passed through an
//             optional square-law (gamma) map. The result is captured into a
//             per-channel duty shadow at that channel's own period start, so
//             duty changes never cut a pulse short. Channel ramps can be
//             phase-staggered to spread the LED current peaks.
//
//  Ports    : clk       clock
//             rst_n     asynchronous active-low reset
//             ena       block enable (low: counters hold, writes ignored,
//                       outputs low)
//             wr_en     write strobe
//             wr_addr   channel index to write
//             wr_data   brightness target
//             fade_en   1 = level slews toward target, 0 = level jumps
//             gamma_en  1 = duty = level^2 >> WIDTH, 0 = duty = level
//             pwm_out   registered PWM outputs, one per channel
//             sync_out  one-cycle pulse after the base ramp wraps to 0
//             busy      high while any channel level differs from its target
//
//  Revision : 1.0  initial release
// ============================================================================
module exp_led_pwm_multi #(
    parameter int N            = 8,
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 1,
    parameter int FADE_DIV     = 4,
    parameter int PHASE_SPREAD = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ena,
    input  logic                                 wr_en,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_addr,
    input  logic [WIDTH-1:0]                     wr_data,
    input  logic                                 fade_en,
    input  logic                                 gamma_en,
    output logic [N-1:0]                         pwm_out,
    output logic                                 sync_out,
    output logic                                 busy
);

    localparam int c_AW     = (N > 1) ? $clog2(N) : 1;
    localparam int c_PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_FW     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int c_STRIDE = (1 << WIDTH) / N;

    localparam logic [WIDTH-1:0] c_MAX       = '1;
    localparam logic [c_PW-1:0]  c_PRE_LAST  = c_PW'(PRESCALE - 1);
    localparam logic [c_FW-1:0]  c_FADE_LAST = c_FW'(FADE_DIV - 1);
    // One extra bit so wr_addr can be compared against N even when N is a
    // power of two.
    localparam logic [c_AW:0]    c_N_EXT     = (c_AW + 1)'(N);

    // ------------------------------------------------------------------
    // Shared timebase: prescaler, ramp, period sync, fade divider
    // ------------------------------------------------------------------
    logic [c_PW-1:0]  r_pre;
    logic [WIDTH-1:0] r_ramp;
    logic [c_FW-1:0]  r_fade;
    logic             r_sync;

    logic w_step;
    logic w_wrap;
    logic w_fade_step;
    logic w_wr_ok;

    assign w_step      = ena && (r_pre == c_PRE_LAST);
    assign w_wrap      = w_step && (r_ramp == c_MAX);
    assign w_fade_step = w_wrap && (r_fade == c_FADE_LAST) && fade_en;
    assign w_wr_ok     = wr_en && ena && ({1'b0, wr_addr} < c_N_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (ena) begin
            r_pre <= w_step ? '0 : r_pre + c_PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp <= '0;
        end else if (w_step) begin
            r_ramp <= r_ramp + WIDTH'(1);
        end
    end

    // The divider advances on every wrap; fading itself is gated by fade_en
    // only at the step point, so toggling fade_en never disturbs the cadence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fade <= '0;
        end else if (w_wrap) begin
            r_fade <= (r_fade == c_FADE_LAST) ? '0 : r_fade + c_FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 1'b0;
        end else begin
            r_sync <= w_wrap;
        end
    end

    assign sync_out = r_sync;

    // ------------------------------------------------------------------
    // Per-channel target / level / duty shadow / output
    // ------------------------------------------------------------------
    logic [N-1:0] w_busy_vec;

    for (genvar i = 0; i < N; i++) begin : g_ch
        localparam logic [WIDTH-1:0] c_OFFSET =
            (PHASE_SPREAD != 0) ? WIDTH'(i * c_STRIDE) : '0;

        logic [WIDTH-1:0]   r_target;
        logic [WIDTH-1:0]   r_level;
        logic [WIDTH-1:0]   r_duty_sh;
        logic               r_pwm;
        logic [WIDTH-1:0]   w_phase;
        logic [2*WIDTH-1:0] w_lev_ext;
        logic [2*WIDTH-1:0] w_square;
        logic [WIDTH-1:0]   w_gamma;
        logic [WIDTH-1:0]   w_mapped;
        logic               w_sel;

        assign w_sel     = w_wr_ok && (wr_addr == c_AW'(i));
        // Wrap-around add gives this channel's private view of the ramp.
        assign w_phase   = r_ramp + c_OFFSET;
        assign w_lev_ext = {{WIDTH{1'b0}}, r_level};
        assign w_square  = w_lev_ext * w_lev_ext;
        assign w_gamma   = WIDTH'(w_square >> WIDTH);
        assign w_mapped  = gamma_en ? w_gamma : r_level;

        // A write outranks a simultaneous fade step: the target always
        // follows the write, and the level only moves when not fading.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_target <= '0;
                r_level  <= '0;
            end else if (w_sel) begin
                r_target <= wr_data;
                if (!fade_en) begin
                    r_level <= wr_data;
                end
            end else if (w_fade_step) begin
                if (r_level < r_target) begin
                    r_level <= r_level + WIDTH'(1);
                end else if (r_level > r_target) begin
                    r_level <= r_level - WIDTH'(1);
                end
            end
        end

        // The shadow is refreshed on the step that takes this channel's
        // phase from all-ones back to zero. The compare at that same edge
        // still uses the old duty, so the new value starts cleanly at
        // phase 0 of the next period.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_duty_sh <= '0;
                r_pwm     <= 1'b0;
            end else begin
                if (w_step && (w_phase == c_MAX)) begin
                    r_duty_sh <= w_mapped;
                end
                r_pwm <= ena && (w_phase < r_duty_sh);
            end
        end

        assign pwm_out[i]    = r_pwm;
        assign w_busy_vec[i] = (r_level != r_target);
    end : g_ch

    assign busy = |w_busy_vec;

endmodule : exp_led_pwm_multi
`default_nettype wire
